double_diff_decim: RTL and testbench
====================================

DOUBLE_DIFF_DECIM -- requirements
Module: double_diff_decim

Interface
REQ-001 SHALL have parameter dwi, default 28: input data width, equal to the upstream double-integrator output width.
REQ-002 SHALL have parameter dwo, default 16: output data width.
REQ-003 SHALL have parameter cw, default 8: decimation counter and period width.
REQ-004 SHALL have parameter sw, default 4: shift control width.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port in, input, dwi bits, signed: double-integrator output, a new value every clk.
REQ-008 SHALL have port period, input, cw bits, unsigned: decimation factor P.
REQ-009 SHALL have port shift, input, sw bits, unsigned: arithmetic right-shift applied before saturation.
REQ-010 SHALL have port out, output, dwo bits, signed: decimated double-differenced result.
REQ-011 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new out value.
REQ-012 SHALL have port sample_stb, output, 1 bit: one-cycle pulse, high the cycle after each sample edge.

Function
REQ-013 SHALL keep counter cnt (cw bits); each edge: cnt <= (cnt == Peff-1) ? 0 : cnt+1.
REQ-014 SHALL latch Peff from period only on the edge where cnt wraps to 0 and on reset; a period change mid-interval SHALL take effect at the next interval.
REQ-015 SHALL treat period values 0 and 1 as 2.
REQ-016 A "sample edge" SHALL be an edge with cnt == Peff-1; exactly one sample SHALL occur per Peff clocks.
REQ-017 Stage 1, at a sample edge: d1 <= in - x1; x1 <= in; v1 <= 1. On all other edges v1 <= 0.
REQ-018 Stage 2, edge after v1: d2 <= d1 - d1p; d1p <= d1; v2 <= 1. On all other edges v2 <= 0.
REQ-019 Stage 3, edge after v2: out <= sat(d2 >>> shift); out_valid <= v2 AND primed. On all other edges out_valid <= 0; out holds its value.
REQ-020 All subtractions SHALL be dwi-bit two's-complement, wrapping modulo 2^dwi with no overflow detection, so that wrap in the upstream integrator cancels.
REQ-021 sat() SHALL clamp to [-2^(dwo-1), 2^(dwo-1)-1] when the shifted value exceeds dwo signed range, otherwise truncate to dwo bits exactly.
REQ-022 shift SHALL be sampled on the stage-3 edge.
REQ-023 sample_stb SHALL equal v1.
REQ-024 Latency from a sample edge to the out_valid-high cycle SHALL be 3 clk.
REQ-025 A 2-bit saturating priming counter SHALL increment per sample edge. primed SHALL be set when it reaches 2 at the sample feeding stage 3, so the first two outputs after reset are suppressed and the third sample yields the first valid out.

Reset
REQ-026 While rst_n=0 at an edge, the block SHALL clear cnt, x1, d1, d1p, d2, out, v1, v2, out_valid, sample_stb and the priming counter to 0, and load Peff from period (0 or 1 becomes 2).
REQ-027 Reset SHALL take precedence over all other updates, including a coincident sample edge.
REQ-028 After rst_n rises, the first sample edge SHALL occur Peff edges later.
REQ-029 Reset mid-operation SHALL discard in-flight stage data and restart priming.

Verification
REQ-030 Reset: rst_n=0 for 2 clk with arbitrary in -> out=0, out_valid=0, sample_stb=0; first sample_stb pulse exactly Peff+1 edges after release.
REQ-031 CIC chain: in driven by double-integrator model fed constant 3, period=4, shift=0 -> first two outputs suppressed, then out=48 every 4 clk, out_valid 3 clk after each sample edge.
REQ-032 Wrap: samples 2^27-10, then -2^27+10, then -2^27+30, dwi=28 -> d1=20 then 20, d2=0, no saturation.
REQ-033 Saturation: d2=40000, dwo=16: shift=0 -> out=32767; shift=1 -> out=20000; d2=-40000, shift=0 -> out=-32768.
REQ-034 Period: period changed 4->7 at cnt=1 -> current interval 4 clk, subsequent 7 clk; period=0 or 1 -> interval 2 clk.
REQ-035 Reset mid-stream: rst_n=0 one clk between samples, steady input -> no out_valid for the next two samples, valid from the third, out value matches pre-reset steady value.

Source files
------------

// File: rtl/double_diff_decim.sv
// Decimating double differentiator (CIC comb pair) with arithmetic shift and saturation.
// One sample is taken every Peff clocks; the differenced result is valid three clocks later.
module double_diff_decim #(
  parameter int dwi = 28,
  parameter int dwo = 16,
  parameter int cw  = 8,
  parameter int sw  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [dwi-1:0] in,
  input  logic        [cw-1:0]  period,
  input  logic        [sw-1:0]  shift,
  output logic signed [dwo-1:0] out,
  output logic                  out_valid,
  output logic                  sample_stb
);

  logic        [cw-1:0]  r_cnt;
  logic        [cw-1:0]  r_peff;
  logic signed [dwi-1:0] r_x1;
  logic signed [dwi-1:0] r_d1;
  logic signed [dwi-1:0] r_d1p;
  logic signed [dwi-1:0] r_d2;
  logic                  r_v1;
  logic                  r_v2;
  logic                  r_p1;
  logic                  r_p2;
  logic        [1:0]     r_prime;
  logic signed [dwo-1:0] r_out;
  logic                  r_out_valid;

  logic        [cw-1:0]  w_peff_next;
  logic                  w_sample;
  logic signed [dwi-1:0] w_shifted;
  logic        [dwi-dwo:0] w_hi;
  logic                  w_ovf;
  logic signed [dwo-1:0] w_sat;

  // Periods below 2 would make the counter compare degenerate, so they run as 2.
  assign w_peff_next = (period < cw'(2)) ? cw'(2) : period;
  assign w_sample    = (r_cnt == r_peff - cw'(1));

  // Overflow when the bits above the output sign bit are not a pure sign extension.
  assign w_shifted = r_d2 >>> shift;
  assign w_hi      = w_shifted[dwi-1:dwo-1];
  assign w_ovf     = !((&w_hi) || !(|w_hi));

  always_comb begin
    w_sat = w_shifted[dwo-1:0];
    if (w_ovf) begin
      w_sat = w_hi[dwi-dwo] ? {1'b1, {(dwo-1){1'b0}}} : {1'b0, {(dwo-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_peff      <= w_peff_next;
      r_x1        <= '0;
      r_d1        <= '0;
      r_d1p       <= '0;
      r_d2        <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_p1        <= 1'b0;
      r_p2        <= 1'b0;
      r_prime     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_cnt <= w_sample ? '0 : r_cnt + cw'(1);
      r_v1  <= w_sample;
      if (w_sample) begin
        r_peff <= w_peff_next;
        r_d1   <= in - r_x1;
        r_x1   <= in;
        r_p1   <= (r_prime == 2'd2);
        if (r_prime != 2'd2) r_prime <= r_prime + 2'd1;
      end

      r_v2 <= r_v1;
      if (r_v1) begin
        r_d2  <= r_d1 - r_d1p;
        r_d1p <= r_d1;
        r_p2  <= r_p1;
      end

      r_out_valid <= r_v2 && r_p2;
      if (r_v2) r_out <= w_sat;
    end
  end

  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign sample_stb = r_v1;

endmodule

// File: tb/tb_double_diff_decim.sv
// Bench for double_diff_decim: sample-history model checked every cycle, plus directed
// scenarios (reset, CIC chain, wrap, saturation, period changes, mid-stream reset).
module tb_double_diff_decim;

  logic               clk;
  logic               rst_n;
  logic signed [27:0] in_w;
  logic signed [27:0] in_man;
  logic        [7:0]  period;
  logic        [3:0]  shift;
  logic signed [15:0] out;
  logic               out_valid;
  logic               sample_stb;

  int total = 0;
  int bad   = 0;

  // upstream double integrator fed a constant 3, restarted from zero while disabled
  bit     cic_en = 1'b0;
  longint y1 = 0;
  longint y2 = 0;

  double_diff_decim #(.dwi(28), .dwo(16), .cw(8), .sw(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_w),
    .period     (period),
    .shift      (shift),
    .out        (out),
    .out_valid  (out_valid),
    .sample_stb (sample_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!cic_en) begin
      y1 = 0;
      y2 = 0;
    end else begin
      y1 = y1 + 3;
      y2 = y2 + y1;
    end
  end

  assign in_w = cic_en ? y2[27:0] : in_man;

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic longint wrap28(input longint v);
    logic signed [27:0] t;
    t = v[27:0];
    return longint'(t);
  endfunction

  function automatic longint msat(input longint d2, input int sh);
    longint s;
    s = d2 >>> sh;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic int peff_of(input logic [7:0] p);
    return (p < 8'd2) ? 2 : int'(p);
  endfunction

  // Model: every Peff edges a sample x_k is taken; three clocks later the output is
  // sat((x_k - 2x_{k-1} + x_{k-2}) >>> shift), valid from the third sample after reset.
  typedef struct {
    longint due;
    longint d2;
    bit     pr;
  } pend_t;

  pend_t  pq[$];
  bit     m_init = 1'b0;
  longint edge_n = 0;
  int     m_peff = 2;
  int     m_phase = 0;
  int     nsamp = 0;
  longint h1 = 0;
  longint h2 = 0;
  longint mx;
  longint md2;
  bit     e_stb = 1'b0;
  bit     e_val = 1'b0;
  longint e_out = 0;

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      m_init  = 1'b1;
      m_peff  = peff_of(period);
      m_phase = 0;
      h1      = 0;
      h2      = 0;
      nsamp   = 0;
      pq.delete();
      e_stb   = 1'b0;
      e_val   = 1'b0;
      e_out   = 0;
    end else if (m_init) begin
      e_stb = 1'b0;
      e_val = 1'b0;
      if (pq.size() > 0 && pq[0].due == edge_n) begin
        e_out = msat(pq[0].d2, int'(shift));
        e_val = pq[0].pr;
        void'(pq.pop_front());
      end
      if (m_phase == m_peff - 1) begin
        mx  = longint'(in_w);
        md2 = wrap28(mx - 2 * h1 + h2);
        h2  = h1;
        h1  = mx;
        nsamp++;
        pq.push_back('{edge_n + 2, md2, nsamp >= 3});
        e_stb   = 1'b1;
        m_phase = 0;
        m_peff  = peff_of(period);
      end else begin
        m_phase++;
      end
    end
    #1;
    if (m_init) begin
      chk("sample_stb", longint'(sample_stb), longint'(e_stb));
      chk("out_valid", longint'(out_valid), longint'(e_val));
      chk("out", longint'(out), e_out);
    end
  end

  task automatic wait_stb(input string nm, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (sample_stb) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({nm, "_stb_timeout"}, 0, 1);
  endtask

  // returns the output value, sample pulses seen on the way, and cycles waited
  task automatic wait_valid(input string nm, output longint v, output int ns, output int cyc);
    bit seen;
    seen = 1'b0;
    ns = 0;
    cyc = 0;
    v = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      cyc++;
      if (sample_stb) ns++;
      if (out_valid) begin
        seen = 1'b1;
        v = longint'(out);
        break;
      end
    end
    if (!seen) chk({nm, "_valid_timeout"}, 0, 1);
  endtask

  initial begin
    longint v;
    int     n;
    int     ns;
    int     cyc;

    rst_n  = 1'b0;
    period = 8'd4;
    shift  = 4'd0;
    in_man = 28'($urandom);

    // reset with arbitrary input
    repeat (2) begin
      @(negedge clk);
      in_man = 28'($urandom);
    end
    chk("rst_out", longint'(out), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sample_stb", longint'(sample_stb), 0);
    rst_n = 1'b1;
    wait_stb("rst", n);
    // edges counted from the last edge that saw rst_n low
    chk("rst_first_stb_edges", longint'(n + 1), 5);

    // CIC chain: constant 3 through a double integrator, P=4 -> 3*4*4
    @(negedge clk);
    rst_n  = 1'b0;
    cic_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid("cic1", v, ns, cyc);
    chk("cic1_samples_before_valid", longint'(ns), 3);
    chk("cic1_out", v, 48);
    wait_valid("cic2", v, ns, cyc);
    chk("cic2_out", v, 48);
    chk("cic2_spacing", longint'(cyc), 4);
    wait_valid("cic3", v, ns, cyc);
    chk("cic3_out", v, 48);

    // reset one clock between samples, integrator keeps running
    wait_stb("mid", n);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid("mid", v, ns, cyc);
    chk("mid_samples_before_valid", longint'(ns), 3);
    chk("mid_out", v, 48);

    // two's-complement wrap cancels in the differences
    @(negedge clk);
    cic_en = 1'b0;
    in_man = 28'((1 << 27) - 10);
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_stb("wrap1", n);
    in_man = 28'(-(1 << 27) + 10);
    wait_stb("wrap2", n);
    in_man = 28'(-(1 << 27) + 30);
    wait_stb("wrap3", n);
    wait_valid("wrap", v, ns, cyc);
    chk("wrap_out", v, 0);

    // saturation: d2 = 40000, 40000, -40000
    @(negedge clk);
    in_man = 28'(0);
    shift  = 4'd0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_stb("sat1", n);
    wait_stb("sat2", n);
    in_man = 28'(40000);
    wait_stb("sat3", n);
    in_man = 28'(120000);
    wait_valid("sat_pos", v, ns, cyc);
    chk("sat_pos_shift0", v, 32767);
    shift = 4'd1;
    wait_stb("sat4", n);
    in_man = 28'(160000);
    wait_valid("sat_shift1", v, ns, cyc);
    chk("sat_shift1", v, 20000);
    shift = 4'd0;
    wait_valid("sat_neg", v, ns, cyc);
    chk("sat_neg_shift0", v, -32768);

    // period 4 -> 7 changed at cnt=1, then 0 and 1 treated as 2
    wait_stb("per0", n);
    @(negedge clk);
    period = 8'd7;
    wait_stb("per_cur", n);
    chk("period_current_interval", longint'(n + 1), 4);
    wait_stb("per7a", n);
    chk("period_7_interval_a", longint'(n), 7);
    wait_stb("per7b", n);
    chk("period_7_interval_b", longint'(n), 7);
    period = 8'd0;
    wait_stb("per7c", n);
    chk("period_7_until_wrap", longint'(n), 7);
    wait_stb("per0a", n);
    chk("period_0_interval", longint'(n), 2);
    period = 8'd1;
    wait_stb("per0b", n);
    chk("period_0_interval_b", longint'(n), 2);
    wait_stb("per1", n);
    chk("period_1_interval", longint'(n), 2);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
